// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 device-to-host frame decoder producing scan-code events.
//
// Parameters:
//   TIMEOUT - ce cycles without a filtered falling edge before a partial frame
//             is abandoned (12-bit counter)
//   FILTER  - consecutive identical ce samples needed to change filtered clock
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   ce     in   clock enable; all state advances only when ce=1
//   ps2ck  in   raw PS/2 clock pin (async, idle high)
//   ps2d   in   raw PS/2 data pin (async, idle high)
//   strb   out  one-ce-period strobe per decoded key event
//   make   out  0 = press, 1 = release (F0 seen)
//   code   out  scan code of the event (prefix bytes excluded)
//   ext    out  event was E0-prefixed
//   err    out  one-ce-period pulse on parity or stop-bit error
module ps2_receiver #(
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [11:0] TO = 12'(TIMEOUT);

  state_t            state, state_n;
  logic [1:0]        ck_s, d_s;
  logic [FILTER-1:0] filt, filt_n;
  logic              fck, fck_n, fall, din;
  logic [2:0]        bitcnt, bitcnt_n;
  logic [7:0]        sh, sh_n;
  logic              par, par_n, parok, parok_n;
  logic [11:0]       tcnt, tcnt_n;
  logic              brk, brk_n, extf, extf_n;
  logic              strb_n, err_n, make_n, ext_n;
  logic [7:0]        code_n;

  always_comb begin
    // Edge is judged on the filter contents after this cycle's shift, so the
    // data sample taken alongside it is aligned with the same sync depth.
    filt_n = {filt[FILTER-2:0], ck_s[1]};
    fck_n  = fck;
    if (filt_n == '0)      fck_n = 1'b0;
    else if (filt_n == '1) fck_n = 1'b1;
    fall = fck & ~fck_n;
    din  = d_s[1];

    state_n  = state;
    bitcnt_n = bitcnt;
    sh_n     = sh;
    par_n    = par;
    parok_n  = parok;
    tcnt_n   = tcnt;
    brk_n    = brk;
    extf_n   = extf;
    strb_n   = 1'b0;
    err_n    = 1'b0;
    make_n   = make;
    code_n   = code;
    ext_n    = ext;

    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (fall && !din) begin
          state_n  = DATA;
          bitcnt_n = '0;
          par_n    = 1'b0;
        end
      end
      DATA: begin
        if (fall) begin
          sh_n     = {din, sh[7:1]};
          par_n    = par ^ din;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parok_n = par ^ din;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (din && parok) begin
            if (sh == 8'hF0) begin
              brk_n = 1'b1;
            end else if (sh == 8'hE0) begin
              extf_n = 1'b1;
            end else begin
              strb_n = 1'b1;
              code_n = sh;
              make_n = brk;
              ext_n  = extf;
              brk_n  = 1'b0;
              extf_n = 1'b0;
            end
          end else begin
            err_n  = 1'b1;
            brk_n  = 1'b0;
            extf_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Edge beats expiry: a falling edge clears the counter even on the
    // cycle it would have reached TIMEOUT.
    if (state != IDLE) begin
      if (fall) begin
        tcnt_n = '0;
      end else begin
        tcnt_n = tcnt + 12'd1;
        if (tcnt_n == TO) begin
          state_n = IDLE;
          brk_n   = 1'b0;
          extf_n  = 1'b0;
          tcnt_n  = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ck_s   <= '1;
      d_s    <= '1;
      filt   <= '1;
      fck    <= 1'b1;
      bitcnt <= '0;
      sh     <= '0;
      par    <= 1'b0;
      parok  <= 1'b0;
      tcnt   <= '0;
      brk    <= 1'b0;
      extf   <= 1'b0;
      strb   <= 1'b0;
      err    <= 1'b0;
      make   <= 1'b1;
      code   <= 8'h00;
      ext    <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      ck_s   <= {ck_s[0], ps2ck};
      d_s    <= {d_s[0], ps2d};
      filt   <= filt_n;
      fck    <= fck_n;
      bitcnt <= bitcnt_n;
      sh     <= sh_n;
      par    <= par_n;
      parok  <= parok_n;
      tcnt   <= tcnt_n;
      brk    <= brk_n;
      extf   <= extf_n;
      strb   <= strb_n;
      err    <= err_n;
      make   <= make_n;
      code   <= code_n;
      ext    <= ext_n;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed, table-driven bench for ps2_receiver.
module tb_ps2_receiver;

  localparam int unsigned TIMEOUT = 4095;
  localparam int unsigned FILTER  = 8;
  localparam int unsigned HALF    = 20;   // ce cycles per PS/2 clock half period
  localparam int unsigned GAP     = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce    = 1'b1;
  logic       ps2ck = 1'b1;
  logic       ps2d  = 1'b1;
  logic       strb, make, ext, err;
  logic [7:0] code;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned strb_cnt = 0;
  int unsigned err_cnt  = 0;
  int unsigned both_cnt = 0;

  ps2_receiver #(.TIMEOUT(TIMEOUT), .FILTER(FILTER)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2ck(ps2ck), .ps2d(ps2d),
    .strb(strb), .make(make), .code(code), .ext(ext), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (strb) strb_cnt++;
    if (err) err_cnt++;
    if (strb && err) both_cnt++;
  end

  // Frames in bytes[] go out index 0 first; corruption applies to the last one.
  typedef struct {
    logic [2:0][7:0] bytes;
    int unsigned     n;
    bit              bad_par;
    bit              bad_stop;
    int unsigned     exp_strb;
    int unsigned     exp_err;
    logic [7:0]      exp_code;
    logic            exp_make;
    logic            exp_ext;
  } vec_t;

  vec_t vecs[9];

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    cyc(HALF);
    ps2ck = 1'b0;
    cyc(HALF);
    ps2ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2d = 1'b1;
    cyc(GAP);
  endtask

  task automatic send_partial(input int unsigned nbits);
    send_bit(1'b0);
    for (int i = 1; i < int'(nbits); i++) send_bit(1'b1);
    ps2d = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] c, input logic m, input logic e);
    check({tag, ".code"}, 32'(code), 32'(c));
    check({tag, ".make"}, 32'(make), 32'(m));
    check({tag, ".ext"},  32'(ext),  32'(e));
  endtask

  initial begin
    int unsigned s0, e0;

    vecs[0] = '{'{8'h00, 8'h00, 8'h1C}, 1, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{'{8'h00, 8'h1C, 8'hF0}, 2, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
    vecs[2] = '{'{8'h75, 8'hF0, 8'hE0}, 3, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[3] = '{'{8'h00, 8'h00, 8'h75}, 1, 1'b0, 1'b0, 1, 0, 8'h75, 1'b0, 1'b0};
    vecs[4] = '{'{8'h00, 8'h1C, 8'hE0}, 2, 1'b1, 1'b0, 0, 1, 8'h75, 1'b0, 1'b0};
    vecs[5] = '{'{8'h00, 8'h00, 8'h75}, 1, 1'b0, 1'b0, 1, 0, 8'h75, 1'b0, 1'b0};
    vecs[6] = '{'{8'h00, 8'h00, 8'hE1}, 1, 1'b0, 1'b0, 1, 0, 8'hE1, 1'b0, 1'b0};
    vecs[7] = '{'{8'h00, 8'h12, 8'hF0}, 2, 1'b0, 1'b1, 0, 1, 8'hE1, 1'b0, 1'b0};
    vecs[8] = '{'{8'h00, 8'h00, 8'h5A}, 1, 1'b0, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b0};

    cyc(5);
    check("rst.strb", 32'(strb), 32'd0);
    check("rst.err",  32'(err),  32'd0);
    check_outputs("rst", 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(GAP);

    for (int v = 0; v < 9; v++) begin
      s0 = strb_cnt;
      e0 = err_cnt;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        if (k == int'(vecs[v].n) - 1)
          send_frame(vecs[v].bytes[k], vecs[v].bad_par, vecs[v].bad_stop);
        else
          send_frame(vecs[v].bytes[k], 1'b0, 1'b0);
      end
      check($sformatf("v%0d.nstrb", v), strb_cnt - s0, vecs[v].exp_strb);
      check($sformatf("v%0d.nerr", v),  err_cnt - e0,  vecs[v].exp_err);
      check_outputs($sformatf("v%0d", v), vecs[v].exp_code, vecs[v].exp_make, vecs[v].exp_ext);
    end

    // Partial frame abandoned by timeout, then a clean frame decodes.
    s0 = strb_cnt;
    e0 = err_cnt;
    send_partial(5);
    cyc(TIMEOUT + 10);
    send_frame(8'h29, 1'b0, 1'b0);
    check("to.nstrb", strb_cnt - s0, 32'd1);
    check("to.nerr",  err_cnt - e0,  32'd0);
    check_outputs("to", 8'h29, 1'b0, 1'b0);

    // Pending E0 then reset mid-frame: outputs and flags return to reset values.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_partial(5);
    reset = 1'b1;
    cyc(2);
    check("mr.strb", 32'(strb), 32'd0);
    check("mr.err",  32'(err),  32'd0);
    check_outputs("mr", 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(GAP);
    s0 = strb_cnt;
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    check("mr2.nstrb", strb_cnt - s0, 32'd1);
    check("mr2.nerr",  err_cnt - e0,  32'd0);
    check_outputs("mr2", 8'h29, 1'b0, 1'b0);

    // Short low glitch with data low would look like a start bit if it passed.
    s0 = strb_cnt;
    e0 = err_cnt;
    ps2d  = 1'b0;
    ps2ck = 1'b0;
    cyc(3);
    ps2ck = 1'b1;
    cyc(HALF);
    ps2d = 1'b1;
    cyc(GAP);
    check("gl.nstrb", strb_cnt - s0, 32'd0);
    check("gl.nerr",  err_cnt - e0,  32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("gl2.nstrb", strb_cnt - s0, 32'd1);
    check("gl2.nerr",  err_cnt - e0,  32'd0);
    check_outputs("gl2", 8'h1C, 1'b0, 1'b0);

    check("strb_err_overlap", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
